// File: rtl/fma_issue_sequencer_pkg.sv
// Shared control definitions for the FMA issue sequencer and the datapath wrapper.
package fma_ctrl_pkg;

  localparam int FMA_STAGES_DFLT = 3;
  localparam int FMA_TAG_DFLT    = 4;

  // One datapath stage slot as seen by the datapath wrapper
  typedef struct packed {
    logic                    vld;
    logic                    src;
    logic [FMA_TAG_DFLT-1:0] tag;
  } fma_slot_t;

endpackage

// File: rtl/fma_issue_sequencer_if.sv
// Requester, flush and result handshake bundle of the FMA issue sequencer.
interface fma_issue_sequencer_if #(
  parameter int PARM_STAGES = 3,
  parameter int PARM_TAG    = 4
);

  logic                               Req0_valid_i;
  logic [PARM_TAG-1:0]                Req0_tag_i;
  logic                               Req0_ready_o;
  logic                               Req1_valid_i;
  logic [PARM_TAG-1:0]                Req1_tag_i;
  logic                               Req1_ready_o;
  logic                               Flush_i;
  logic                               Op_issue_o;
  logic                               Op_sel_o;
  logic [PARM_STAGES-1:0]             Stage_en_o;
  logic                               Res_valid_o;
  logic                               Res_ready_i;
  logic [PARM_TAG-1:0]                Res_tag_o;
  logic                               Res_src_o;
  logic [$clog2(PARM_STAGES+1)-1:0]   Inflight_o;
  logic                               Busy_o;

  modport master (
    output Req0_valid_i, Req0_tag_i, Req1_valid_i, Req1_tag_i, Flush_i, Res_ready_i,
    input  Req0_ready_o, Req1_ready_o, Op_issue_o, Op_sel_o, Stage_en_o,
           Res_valid_o, Res_tag_o, Res_src_o, Inflight_o, Busy_o
  );

  modport slave (
    input  Req0_valid_i, Req0_tag_i, Req1_valid_i, Req1_tag_i, Flush_i, Res_ready_i,
    output Req0_ready_o, Req1_ready_o, Op_issue_o, Op_sel_o, Stage_en_o,
           Res_valid_o, Res_tag_o, Res_src_o, Inflight_o, Busy_o
  );

endinterface

// File: rtl/fma_issue_sequencer_rr_arbiter2.sv
// Two-input round-robin arbiter; the pointer only moves when the grant is actually used.
module rr_arbiter2 (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_req,
  input  logic       i_upd_en,
  output logic       o_gnt_vld,
  output logic       o_gnt_idx
);

  logic r_rr;
  logic w_gnt_idx;

  // Grant selection: a lone requester wins outright, a tie goes to the pointer
  always_comb begin
    w_gnt_idx = 1'b0;
    case (i_req)
      2'b01:   w_gnt_idx = 1'b0;
      2'b10:   w_gnt_idx = 1'b1;
      2'b11:   w_gnt_idx = r_rr;
      default: w_gnt_idx = 1'b0;
    endcase
  end

  // Pointer update: after a used grant the other requester gets priority
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rr <= 1'b0;
    end else if (i_upd_en) begin
      r_rr <= ~w_gnt_idx;
    end else begin
      r_rr <= r_rr;
    end
  end

  assign o_gnt_vld = |i_req;
  assign o_gnt_idx = w_gnt_idx;

endmodule

// File: rtl/fma_issue_sequencer.sv
// Issues requests from two requesters into the shared FMA pipeline and tracks
// the tag/source of each in-flight operation in lockstep with the datapath stages.
module fma_issue_sequencer
  import fma_ctrl_pkg::*;
#(
  parameter int PARM_STAGES = FMA_STAGES_DFLT,
  parameter int PARM_TAG    = FMA_TAG_DFLT
) (
  input  logic                 Clk_i,
  input  logic                 Rst_i,
  fma_issue_sequencer_if.slave bus
);

  localparam int LAST = PARM_STAGES - 1;
  localparam int CW   = $clog2(PARM_STAGES + 1);

  logic [PARM_STAGES-1:0] r_vld;
  logic [PARM_STAGES-1:0] r_src;
  logic [PARM_TAG-1:0]    r_tag [PARM_STAGES];

  logic                   w_stall;
  logic                   w_issue;
  logic                   w_gnt_vld;
  logic                   w_gnt_idx;
  logic [PARM_TAG-1:0]    w_gnt_tag;

  rr_arbiter2 u_arb (
    .i_clk     (Clk_i),
    .i_rst     (Rst_i),
    .i_req     ({bus.Req1_valid_i, bus.Req0_valid_i}),
    .i_upd_en  (w_issue),
    .o_gnt_vld (w_gnt_vld),
    .o_gnt_idx (w_gnt_idx)
  );

  // Global stall on an unaccepted result; flush suppresses any new issue
  always_comb begin
    w_stall = r_vld[LAST] & ~bus.Res_ready_i;
    w_issue = w_gnt_vld & ~w_stall & ~bus.Flush_i;
    if (w_gnt_idx) begin
      w_gnt_tag = bus.Req1_tag_i;
    end else begin
      w_gnt_tag = bus.Req0_tag_i;
    end
  end

  // Stage tracker: reset beats flush, flush beats stall, otherwise shift
  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      r_vld <= '0;
      r_src <= '0;
      for (int s = 0; s < PARM_STAGES; s++) begin
        r_tag[s] <= '0;
      end
    end else if (bus.Flush_i) begin
      r_vld <= '0;
    end else if (!w_stall) begin
      r_vld[0] <= w_issue;
      r_src[0] <= w_gnt_idx;
      r_tag[0] <= w_gnt_tag;
      for (int s = 1; s < PARM_STAGES; s++) begin
        r_vld[s] <= r_vld[s-1];
        r_src[s] <= r_src[s-1];
        r_tag[s] <= r_tag[s-1];
      end
    end
  end

  assign bus.Req0_ready_o = w_issue & ~w_gnt_idx;
  assign bus.Req1_ready_o = w_issue & w_gnt_idx;
  assign bus.Op_issue_o   = w_issue;
  assign bus.Op_sel_o     = w_gnt_vld & w_gnt_idx;
  assign bus.Stage_en_o   = {PARM_STAGES{~w_stall}};
  assign bus.Res_valid_o  = r_vld[LAST];
  assign bus.Res_tag_o    = r_tag[LAST];
  assign bus.Res_src_o    = r_src[LAST];
  assign bus.Inflight_o   = CW'($countones(r_vld));
  assign bus.Busy_o       = |r_vld;

endmodule
